// File: rtl/arith_pkg.sv
// Shared types and helpers for the iterative arithmetic units (divider FSM states, counter sizing).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  // Width of an iteration counter that must reach width-1; never narrower than one bit.
  function automatic int iterW(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and try to subtract the divisor.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // A borrow out of the extended subtraction means the divisor did not fit: restore.
  always_comb begin
    trial   = {rem_in, bit_in} - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], bit_in};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with start/done handshake; WIDTH cycles per division.
// Optional signed operation is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int ITER_W = iterW(WIDTH);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

  div_state_e state_q, state_d;
  logic [WIDTH-1:0]  remAcc_q, remAcc_d;
  logic [WIDTH-1:0]  qSh_q, qSh_d;
  logic [WIDTH-1:0]  divisor_q, divisor_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              zeroDiv_q, zeroDiv_d;
  logic              negQ_q, negQ_d;
  logic              negR_q, negR_d;
  logic              ovfPend_q, ovfPend_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              divByZero_q, divByZero_d;
  logic              overflow_q, overflow_d;

  logic             signedOp;
  logic             dividendNeg, divisorNeg, divisorZero;
  logic [WIDTH-1:0] dividendMag, divisorMag;
  logic [WIDTH-1:0] stepRem, qShNext;
  logic             stepBit;

`ifdef SEQ_DIV_SIGNED_EN
  assign signedOp = signed_op;
`else
  assign signedOp = 1'b0;
`endif

  assign divisorZero = (divisor == '0);
  assign dividendNeg = signedOp && dividend[WIDTH-1];
  assign divisorNeg  = signedOp && divisor[WIDTH-1];
  assign dividendMag = dividendNeg ? (~dividend + 1'b1) : dividend;
  assign divisorMag  = divisorNeg ? (~divisor + 1'b1) : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (remAcc_q),
    .bit_in (qSh_q[WIDTH-1]),
    .divisor(divisor_q),
    .rem_out(stepRem),
    .q_bit  (stepBit)
  );

  assign qShNext = {qSh_q[WIDTH-2:0], stepBit};

  // A zero divisor still spends one CALC cycle so its done lands one edge after accept;
  // the raw dividend is kept in qSh so it can be returned as the remainder.
  always_comb begin
    state_d     = state_q;
    remAcc_d    = remAcc_q;
    qSh_d       = qSh_q;
    divisor_d   = divisor_q;
    iter_d      = iter_q;
    zeroDiv_d   = zeroDiv_q;
    negQ_d      = negQ_q;
    negR_d      = negR_q;
    ovfPend_d   = ovfPend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divByZero_d = divByZero_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CALC;
          remAcc_d  = '0;
          iter_d    = '0;
          divisor_d = divisorMag;
          zeroDiv_d = divisorZero;
          qSh_d     = divisorZero ? dividend : dividendMag;
          negQ_d    = !divisorZero && (dividendNeg ^ divisorNeg);
          negR_d    = !divisorZero && dividendNeg;
          ovfPend_d = signedOp && (dividend == MIN_VAL) && (&divisor);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      CALC: begin
        if (zeroDiv_q) begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = qSh_q;
          divByZero_d = 1'b1;
          overflow_d  = 1'b0;
        end else begin
          remAcc_d = stepRem;
          qSh_d    = qShNext;
          iter_d   = iter_q + 1'b1;
          if (iter_q == LAST_ITER) begin
            state_d     = DONE;
            quotient_d  = negQ_q ? (~qShNext + 1'b1) : qShNext;
            remainder_d = negR_q ? (~stepRem + 1'b1) : stepRem;
            divByZero_d = 1'b0;
            overflow_d  = ovfPend_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remAcc_q    <= '0;
      qSh_q       <= '0;
      divisor_q   <= '0;
      iter_q      <= '0;
      zeroDiv_q   <= 1'b0;
      negQ_q      <= 1'b0;
      negR_q      <= 1'b0;
      ovfPend_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divByZero_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remAcc_q    <= remAcc_d;
      qSh_q       <= qSh_d;
      divisor_q   <= divisor_d;
      iter_q      <= iter_d;
      zeroDiv_q   <= zeroDiv_d;
      negQ_q      <= negQ_d;
      negR_q      <= negR_d;
      ovfPend_q   <= ovfPend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divByZero_q <= divByZero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = divByZero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8); signed vectors run only when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
  logic             signedOp;
`endif
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  int checkCount = 0;
  int errCount   = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef SEQ_DIV_SIGNED_EN
    .signed_op  (signedOp),
`endif
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called at a negedge; start is seen by exactly one rising edge (the accept edge k).
  // Returns at the negedge just after edge k.
  task automatic applyStimulus(input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges since accept until done is seen; busyCnt counts busy samples before done.
  task automatic waitDone(input int startLat, output int lat, output int busyCnt);
    lat     = startLat;
    busyCnt = 0;
    while (!done && lat < 40) begin
      if (busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, busyCnt, doneSeen;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
    signedOp = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstQ", quotient, 0);
    checkOutput("rstR", remainder, 0);
    checkOutput("rstDbz", div_by_zero, 0);
    checkOutput("rstOvf", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 / 7
    applyStimulus(8'd100, 8'd7);
    waitDone(0, lat, busyCnt);
    checkOutput("lat100", lat, 8);
    checkOutput("busy100", busyCnt, 8);
    checkOutput("q100", quotient, 14);
    checkOutput("r100", remainder, 2);
    checkOutput("dbz100", div_by_zero, 0);
    checkOutput("ovf100", overflow, 0);
    @(negedge clk);
    checkOutput("donePulse100", done, 0);
    checkOutput("qHeld100", quotient, 14);

    // 255 / 1 then 5 / 9 issued in the done cycle
    applyStimulus(8'd255, 8'd1);
    waitDone(0, lat, busyCnt);
    checkOutput("lat255", lat, 8);
    checkOutput("q255", quotient, 255);
    checkOutput("r255", remainder, 0);
    applyStimulus(8'd5, 8'd9);
    checkOutput("b2bDone", done, 0);
    checkOutput("b2bBusy", busy, 1);
    checkOutput("b2bHeldQ", quotient, 255);
    waitDone(0, lat, busyCnt);
    checkOutput("lat5", lat, 8);
    checkOutput("q5", quotient, 0);
    checkOutput("r5", remainder, 5);

    // 37 / 0
    @(negedge clk);
    applyStimulus(8'd37, 8'd0);
    waitDone(0, lat, busyCnt);
    checkOutput("lat37", lat, 1);
    checkOutput("dbz37", div_by_zero, 1);
    checkOutput("q37", quotient, 8'hFF);
    checkOutput("r37", remainder, 37);
    @(negedge clk);
    checkOutput("busyAfter37", busy, 0);
    checkOutput("dbzSticky37", div_by_zero, 1);

    // 200 / 3 with an ignored start at edge k+3
    applyStimulus(8'd200, 8'd3);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd10;
    divisor  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    waitDone(3, lat, busyCnt);
    checkOutput("lat200", lat, 8);
    checkOutput("q200", quotient, 66);
    checkOutput("r200", remainder, 2);
    checkOutput("dbz200", div_by_zero, 0);

    // Unsigned 0xF9 / 2
    @(negedge clk);
`ifdef SEQ_DIV_SIGNED_EN
    signedOp = 1'b0;
`endif
    applyStimulus(8'hF9, 8'd2);
    waitDone(0, lat, busyCnt);
    checkOutput("qF9", quotient, 124);
    checkOutput("rF9", remainder, 1);
    checkOutput("ovfF9", overflow, 0);

`ifdef SEQ_DIV_SIGNED_EN
    @(negedge clk);
    signedOp = 1'b1;
    applyStimulus(8'hF9, 8'd2);
    waitDone(0, lat, busyCnt);
    checkOutput("latNeg7", lat, 8);
    checkOutput("qNeg7", quotient, 8'hFD);
    checkOutput("rNeg7", remainder, 8'hFF);
    checkOutput("ovfNeg7", overflow, 0);
    @(negedge clk);
    applyStimulus(8'h80, 8'hFF);
    waitDone(0, lat, busyCnt);
    checkOutput("qMin", quotient, 8'h80);
    checkOutput("rMin", remainder, 0);
    checkOutput("ovfMin", overflow, 1);
    signedOp = 1'b0;
`endif

    // 200 / 3 aborted by reset at edge k+4
    @(negedge clk);
    applyStimulus(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortQ", quotient, 0);
    checkOutput("abortR", remainder, 0);
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abortNoDone", doneSeen, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
